// File: rtl/mem_result_writer.sv
// mem_result_writer
//   Write-back end of the memory-to-memory transfer datapath. Sums from the
//   adder stage arrive over a valid/ready handshake, are buffered in a small
//   FIFO, and are written to consecutive destination addresses starting at a
//   programmed base. A one-cycle done pulse follows the final accepted write.
//
// Ports:
//   clk        : system clock, rising edge
//   reset_n    : asynchronous active-low reset
//   start      : one-cycle pulse, latches base_addr/count (IDLE only)
//   base_addr  : first destination address
//   count      : number of words to write (0 = immediate done)
//   res_data   : result word from the adder stage
//   res_valid  : res_data valid
//   res_ready  : writer can accept a result this cycle
//   mem_we     : memory write request
//   mem_addr   : memory write address
//   mem_wdata  : memory write data
//   mem_ready  : memory accepts the write this cycle
//   busy       : transfer in progress
//   done       : one-cycle pulse after the final write is accepted
module mem_result_writer #(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic [DATA_W-1:0] res_data,
  input  logic              res_valid,
  output logic              res_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  localparam logic [PTR_W:0]    PTR_ONE  = (PTR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_cnt_q, addr_cnt_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [ADDR_W:0]     accepted_cnt_q, accepted_cnt_d;
  logic [ADDR_W:0]     written_cnt_q, written_cnt_d;
  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PTR_W:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]      rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   fifo_d [FIFO_DEPTH];

  logic [PTR_W-1:0]    wr_idx;
  logic [PTR_W-1:0]    rd_idx;
  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;

  assign wr_idx     = wr_ptr_q[PTR_W-1:0];
  assign rd_idx     = rd_ptr_q[PTR_W-1:0];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                      (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

  // All outputs decode registered state only, so nothing reaches memory in
  // the same cycle a result is pushed and reset clears them asynchronously.
  // res_ready also stops once every requested word has been accepted.
  assign res_ready = (state_q == RUN) && !fifo_full && (accepted_cnt_q < count_q);
  assign mem_we    = (state_q == RUN) && !fifo_empty;
  assign mem_addr  = addr_cnt_q;
  // Data is gated to zero when no write is requested so the bus idles clean.
  assign mem_wdata = mem_we ? fifo_q[rd_idx] : '0;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);

  assign push = res_valid && res_ready;
  assign pop  = mem_we && mem_ready;

  // Next-state logic. Push and pop are independent in RUN; the transfer ends
  // on the write that brings written_cnt up to the latched count.
  always_comb begin
    state_d        = state_q;
    addr_cnt_d     = addr_cnt_q;
    count_d        = count_q;
    accepted_cnt_d = accepted_cnt_q;
    written_cnt_d  = written_cnt_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    fifo_d         = fifo_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_cnt_d     = base_addr;
          count_d        = count;
          accepted_cnt_d = '0;
          written_cnt_d  = '0;
          wr_ptr_d       = '0;
          rd_ptr_d       = '0;
          state_d        = (count == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (push) begin
          fifo_d[wr_idx] = res_data;
          wr_ptr_d       = wr_ptr_q + PTR_ONE;
          accepted_cnt_d = accepted_cnt_q + CNT_ONE;
        end
        if (pop) begin
          rd_ptr_d      = rd_ptr_q + PTR_ONE;
          addr_cnt_d    = addr_cnt_q + ADDR_ONE;
          written_cnt_d = written_cnt_q + CNT_ONE;
          if ((written_cnt_q + CNT_ONE) == count_q) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously so a mid-transfer
  // reset discards buffered results and drops mem_we immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      addr_cnt_q     <= '0;
      count_q        <= '0;
      accepted_cnt_q <= '0;
      written_cnt_q  <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      fifo_q         <= '{default: '0};
    end else begin
      state_q        <= state_d;
      addr_cnt_q     <= addr_cnt_d;
      count_q        <= count_d;
      accepted_cnt_q <= accepted_cnt_d;
      written_cnt_q  <= written_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      fifo_q         <= fifo_d;
    end
  end

endmodule

// File: tb/tb_mem_result_writer.sv
// tb_mem_result_writer
//   Drives mem_result_writer with directed and randomized transfers and
//   compares every cycle against a transaction-level reference: a queue of
//   accepted results, word counters and the address arithmetic base+k mod 16.
module tb_mem_result_writer;

  localparam int DATA_W     = 8;
  localparam int ADDR_W     = 4;
  localparam int FIFO_DEPTH = 4;

  logic              clk;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] res_data;
  logic              res_valid;
  logic              res_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              busy;
  logic              done;

  int checks;
  int errors;

  // Reference model: transfer phase flags, latched parameters and a queue
  // holding accepted results that have not yet been written.
  bit mRun;
  bit mDone;
  int mBase;
  int mCount;
  int mAccepted;
  int mWritten;
  int dataQ[$];

  // Producer and memory-side stimulus controls.
  int srcQ[$];
  int validProb;
  int readyProb;

  // Observed handshake counters for the current transfer.
  int dutAccepted;
  int dutWrites;
  int doneSeen;

  mem_result_writer #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .res_data  (res_data),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .busy      (busy),
    .done      (done)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit predReady();
    return mRun && (dataQ.size() < FIFO_DEPTH) && (mAccepted < mCount);
  endfunction

  function automatic bit predWe();
    return mRun && (dataQ.size() > 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    mRun      = 1'b0;
    mDone     = 1'b0;
    mBase     = 0;
    mCount    = 0;
    mAccepted = 0;
    mWritten  = 0;
    dataQ.delete();
  endtask

  task automatic beginTransfer();
    dutAccepted = 0;
    dutWrites   = 0;
    doneSeen    = 0;
  endtask

  // Compares all outputs against the reference for the current cycle.
  task automatic checkOutput();
    chk("busy", 32'(busy), 32'(mRun));
    chk("done", 32'(done), 32'(mDone));
    chk("res_ready", 32'(res_ready), 32'(predReady()));
    chk("mem_we", 32'(mem_we), 32'(predWe()));
    if (predWe()) begin
      chk("mem_addr", 32'(mem_addr), 32'((mBase + mWritten) % 16));
      chk("mem_wdata", 32'(mem_wdata), 32'(dataQ[0]));
    end
    if (done) doneSeen++;
  endtask

  // One clock cycle: drive inputs at the falling edge, advance the model by
  // the handshakes that will occur at the rising edge, then check outputs.
  task automatic applyStimulus(input bit st, input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
    bit mPush;
    bit mPop;
    start     = st;
    base_addr = b;
    count     = c;
    res_valid = (srcQ.size() != 0) && ($urandom_range(99) < validProb);
    res_data  = res_valid ? 8'(srcQ[0]) : 8'($urandom_range(255));
    mem_ready = ($urandom_range(99) < readyProb);

    if (res_valid && res_ready) begin
      void'(srcQ.pop_front());
      dutAccepted++;
    end
    if (mem_we && mem_ready) dutWrites++;

    mPush = predReady() && res_valid;
    mPop  = predWe() && mem_ready;
    if (mRun) begin
      if (mPush) begin
        dataQ.push_back(int'(res_data));
        mAccepted++;
      end
      if (mPop) begin
        void'(dataQ.pop_front());
        mWritten++;
        if (mWritten == mCount) begin
          mRun  = 1'b0;
          mDone = 1'b1;
        end
      end
    end else if (mDone) begin
      mDone = 1'b0;
    end else if (st) begin
      mBase     = int'(b);
      mCount    = int'(c);
      mAccepted = 0;
      mWritten  = 0;
      if (c == 0) mDone = 1'b1;
      else        mRun  = 1'b1;
    end

    @(posedge clk);
    @(negedge clk);
    checkOutput();
  endtask

  // Runs until the transfer has finished, with stray start pulses mixed in.
  task automatic waitIdle(input int maxCycles);
    int n;
    n = 0;
    while ((mRun || mDone) && (n < maxCycles)) begin
      applyStimulus(1'($urandom_range(1)), 4'($urandom_range(15)), 5'($urandom_range(31)));
      n++;
    end
    chk("transfer_timeout", 32'(mRun || mDone), 32'd0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    res_data  = '0;
    res_valid = 1'b0;
    mem_ready = 1'b0;
    validProb = 100;
    readyProb = 100;
    modelReset();
    beginTransfer();

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput();
    chk("reset_mem_addr", 32'(mem_addr), 32'd0);
    chk("reset_mem_wdata", 32'(mem_wdata), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput();

    // Basic transfer: three sums to addresses 2..4
    $display("[TB] basic transfer");
    beginTransfer();
    srcQ = '{14, 4, 19};
    applyStimulus(1'b1, 4'h2, 5'd3);
    waitIdle(50);
    chk("t1_writes", 32'(dutWrites), 32'd3);
    chk("t1_done_pulses", 32'(doneSeen), 32'd1);
    chk("t1_busy_after", 32'(busy), 32'd0);

    // Backpressure: memory stalled, FIFO fills to four entries
    $display("[TB] backpressure");
    beginTransfer();
    srcQ.delete();
    for (int i = 0; i < 6; i++) srcQ.push_back(int'($urandom_range(255)));
    readyProb = 0;
    applyStimulus(1'b1, 4'h5, 5'd6);
    repeat (8) applyStimulus(1'b0, 4'($urandom_range(15)), 5'($urandom_range(31)));
    chk("t2_accepted_stalled", 32'(dutAccepted), 32'd4);
    chk("t2_ready_when_full", 32'(res_ready), 32'd0);
    chk("t2_head_addr_held", 32'(mem_addr), 32'h5);
    readyProb = 100;
    waitIdle(50);
    chk("t2_writes", 32'(dutWrites), 32'd6);
    chk("t2_accepted", 32'(dutAccepted), 32'd6);

    // Address wrap from E through 1
    $display("[TB] address wrap");
    beginTransfer();
    srcQ = '{20, 20, 20, 20};
    applyStimulus(1'b1, 4'hE, 5'd4);
    waitIdle(50);
    chk("t3_writes", 32'(dutWrites), 32'd4);
    chk("t3_done_pulses", 32'(doneSeen), 32'd1);
    chk("t3_final_addr", 32'(mem_addr), 32'h2);

    // Zero count, then start ignored mid-transfer
    $display("[TB] zero count and ignored start");
    beginTransfer();
    srcQ.delete();
    applyStimulus(1'b1, 4'h3, 5'd0);
    chk("t4_done_next", 32'(done), 32'd1);
    waitIdle(10);
    chk("t4_zero_writes", 32'(dutWrites), 32'd0);
    chk("t4_zero_done_pulses", 32'(doneSeen), 32'd1);
    beginTransfer();
    srcQ = '{33, 44, 55};
    applyStimulus(1'b1, 4'h5, 5'd3);
    applyStimulus(1'b0, 4'h0, 5'd0);
    applyStimulus(1'b1, 4'h9, 5'd10);
    waitIdle(50);
    chk("t4_writes", 32'(dutWrites), 32'd3);
    chk("t4_done_pulses", 32'(doneSeen), 32'd1);

    // Reset in the middle of a transfer
    $display("[TB] reset mid-transfer");
    beginTransfer();
    srcQ.delete();
    for (int i = 0; i < 5; i++) srcQ.push_back(int'($urandom_range(255)));
    applyStimulus(1'b1, 4'h7, 5'd5);
    for (int n = 0; (n < 20) && (dutWrites < 2); n++)
      applyStimulus(1'b0, 4'h0, 5'd0);
    chk("t5_writes_before_reset", 32'(dutWrites), 32'd2);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_mem_we", 32'(mem_we), 32'd0);
    chk("t5_async_busy", 32'(busy), 32'd0);
    chk("t5_async_res_ready", 32'(res_ready), 32'd0);
    chk("t5_async_done", 32'(done), 32'd0);
    modelReset();
    srcQ.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput();
    chk("t5_no_done_after_reset", 32'(doneSeen), 32'd0);
    beginTransfer();
    srcQ = '{8};
    applyStimulus(1'b1, 4'h0, 5'd1);
    waitIdle(20);
    chk("t5_single_write", 32'(dutWrites), 32'd1);
    chk("t5_done_pulses", 32'(doneSeen), 32'd1);

    // Results offered while idle must not be captured
    $display("[TB] idle gating");
    beginTransfer();
    srcQ = '{85};
    repeat (3) applyStimulus(1'b0, 4'($urandom_range(15)), 5'($urandom_range(31)));
    chk("t6_no_accept_idle", 32'(dutAccepted), 32'd0);
    srcQ = '{17, 34};
    applyStimulus(1'b1, 4'hA, 5'd2);
    waitIdle(20);
    chk("t6_writes", 32'(dutWrites), 32'd2);

    // Randomized transfers with irregular producer and memory timing
    $display("[TB] randomized transfers");
    validProb = 70;
    readyProb = 60;
    for (int t = 0; t < 25; t++) begin
      int c;
      beginTransfer();
      c = int'($urandom_range(20));
      srcQ.delete();
      for (int i = 0; i < c; i++) srcQ.push_back(int'($urandom_range(255)));
      applyStimulus(1'b1, 4'($urandom_range(15)), 5'(c));
      waitIdle(400);
      chk("rand_writes", 32'(dutWrites), 32'(c));
      chk("rand_done_pulses", 32'(doneSeen), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
